// File: rtl/idma_apb_cmd_sequencer.sv
// APB master that programs one iDMA channel per descriptor: base addr, cfg, start, then interrupt clear.
// Optional interrupt-wait timeout is compiled in with `define IDMA_SEQ_TIMEOUT_EN.
module idma_apb_cmd_sequencer #(
  parameter logic [11:0] BASE_ADDR0_OFS = 12'h100,
  parameter logic [11:0] RD_CFG_OFS     = 12'h000,
  parameter logic [11:0] WR_CFG_OFS     = 12'h004,
  parameter logic [11:0] START_OFS      = 12'h008,
  parameter logic [11:0] INTR_CLR_OFS   = 12'h00C,
  parameter int          NUM_BASE       = 6
`ifdef IDMA_SEQ_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [2:0]  cmd_base_idx,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_cfg,
  output logic        done_valid,
  output logic        done_err,
  output logic        busy,
  output logic [11:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  input  logic        intr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCESS    = 3'd2,
    WAIT_INTR = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  step, step_nxt;
  logic        err, err_nxt;
  logic        tmo, tmo_nxt;
  logic        dir_q, dir_nxt;
  logic [2:0]  idx_q, idx_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] cfg_q, cfg_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic unused_prdata;
  assign unused_prdata = ^prdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      step   <= 2'd0;
      err    <= 1'b0;
      tmo    <= 1'b0;
      dir_q  <= 1'b0;
      idx_q  <= 3'd0;
      addr_q <= 32'd0;
      cfg_q  <= 32'd0;
      cnt    <= 16'd0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      err    <= err_nxt;
      tmo    <= tmo_nxt;
      dir_q  <= dir_nxt;
      idx_q  <= idx_nxt;
      addr_q <= addr_nxt;
      cfg_q  <= cfg_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    err_nxt   = err;
    tmo_nxt   = tmo;
    dir_nxt   = dir_q;
    idx_nxt   = idx_q;
    addr_nxt  = addr_q;
    cfg_nxt   = cfg_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_nxt  = cmd_dir;
          idx_nxt  = cmd_base_idx;
          addr_nxt = cmd_addr;
          cfg_nxt  = cmd_cfg;
          step_nxt = 2'd0;
          tmo_nxt  = 1'b0;
          // Out-of-range slot never touches the bus
          if ({29'd0, cmd_base_idx} >= 32'(NUM_BASE)) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          err_nxt = err | pslverr;
          if (pslverr || step == 2'd3) begin
            state_nxt = DONE;
          end else if (step == 2'd2) begin
            cnt_nxt   = 16'd0;
            state_nxt = WAIT_INTR;
          end else begin
            step_nxt  = step + 2'd1;
            state_nxt = SETUP;
          end
        end
      end
      WAIT_INTR: begin
        if (intr) begin
          step_nxt  = 2'd3;
          state_nxt = SETUP;
        end
`ifdef IDMA_SEQ_TIMEOUT_EN
        else if (cnt == 16'(TIMEOUT_CYCLES)) begin
          // Give up, but still clear both channels' interrupt bits
          err_nxt   = 1'b1;
          tmo_nxt   = 1'b1;
          step_nxt  = 2'd3;
          state_nxt = SETUP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    paddr  = 12'd0;
    pwdata = 32'd0;
    if (state == SETUP || state == ACCESS) begin
      case (step)
        2'd0: begin
          paddr  = BASE_ADDR0_OFS + {7'd0, idx_q, 2'b00};
          pwdata = addr_q;
        end
        2'd1: begin
          paddr  = dir_q ? WR_CFG_OFS : RD_CFG_OFS;
          pwdata = cfg_q;
        end
        2'd2: begin
          paddr  = START_OFS;
          pwdata = {30'd0, dir_q, ~dir_q};
        end
        default: begin
          paddr  = INTR_CLR_OFS;
          pwdata = tmo ? 32'h3 : {30'd0, dir_q, ~dir_q};
        end
      endcase
    end
  end

  assign cmd_ready  = (state == IDLE) && aresetn;
  assign busy       = (state != IDLE);
  assign done_valid = (state == DONE);
  assign done_err   = (state == DONE) && err;
  assign psel       = (state == SETUP) || (state == ACCESS);
  assign penable    = (state == ACCESS);
  assign pwrite     = psel;
  assign pstrb      = 4'hF;
  assign pprot      = 3'b000;

endmodule

// File: tb/tb_idma_apb_cmd_sequencer.sv
// Scoreboard bench for idma_apb_cmd_sequencer: directed descriptors, APB slave and interrupt model.
module tb_idma_apb_cmd_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [2:0]  cmd_base_idx;
  logic [31:0] cmd_addr, cmd_cfg;
  logic        done_valid, done_err, busy;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic        pready  = 1'b0;
  logic        pslverr = 1'b0;
  logic        intr    = 1'b0;
  logic [31:0] prdata  = 32'd0;

  always #5 aclk = ~aclk;

  idma_apb_cmd_sequencer #(
    .NUM_BASE(6)
`ifdef IDMA_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base_idx(cmd_base_idx), .cmd_addr(cmd_addr), .cmd_cfg(cmd_cfg),
    .done_valid(done_valid), .done_err(done_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .intr(intr)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } apb_t;

  apb_t exp_apb[$];
  logic exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int accept_cyc = 0;

  // APB slave / interrupt source knobs
  int          ws_cfg   = 0;
  int          acc_cnt  = 0;
  logic        err_en   = 1'b0;
  logic [11:0] err_addr = 12'h000;
  int          intr_dly = 0;
  int          intr_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  always @(posedge aclk) cyc++;

  always begin
    @(posedge aclk);
    #2;
    if (psel && penable) acc_cnt++;
    else acc_cnt = 0;
    pready  = psel && penable && (acc_cnt > ws_cfg);
    pslverr = pready && err_en && (paddr == err_addr);
    if (intr_cnt > 0) begin
      intr_cnt--;
      if (intr_cnt == 0) intr = 1'b1;
    end
    if (pready && paddr == 12'h008 && intr_dly > 0) intr_cnt = intr_dly;
    if (pready && paddr == 12'h00C) intr = 1'b0;
  end

  // Monitor: compare every SETUP/ACCESS cycle against the head of the queue
  always @(negedge aclk) begin
    if (aresetn) begin
      if (psel) begin
        if (exp_apb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_unexpected: got paddr %h pwdata %h, required no transfer", paddr, pwdata);
        end else begin
          chk("apb_paddr", {20'd0, paddr}, {20'd0, exp_apb[0].a});
          chk("apb_pwdata", pwdata, exp_apb[0].d);
          chk("apb_ctl", {24'd0, pwrite, pstrb, pprot}, {24'd0, 1'b1, 4'hF, 3'b000});
          if (penable && pready) void'(exp_apb.pop_front());
        end
      end
      if (done_valid) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done_valid 1 err %b, required none", done_err);
        end else begin
          chk("done_err", {31'd0, done_err}, {31'd0, exp_done.pop_front()});
        end
      end
    end
  end

  task automatic send(input logic d, input logic [2:0] i, input logic [31:0] a, input logic [31:0] c);
    int n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid    = 1'b1;
    cmd_dir      = d;
    cmd_base_idx = i;
    cmd_addr     = a;
    cmd_cfg      = c;
    @(posedge aclk);
    #1;
    accept_cyc   = cyc;
    cmd_valid    = 1'b0;
    cmd_addr     = 32'hFFFF_FFFF;
    cmd_cfg      = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input int max);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < max) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("done_seen", {31'd0, done_cnt != start}, 32'd1);
    chk("apb_queue_drained", exp_apb.size(), 32'd0);
  endtask

  task automatic push4(input logic [11:0] a0, input logic [31:0] d0, input logic [11:0] a1,
                       input logic [31:0] d1, input logic [31:0] st, input logic [31:0] clr);
    exp_apb.push_back('{a0, d0});
    exp_apb.push_back('{a1, d1});
    exp_apb.push_back('{12'h008, st});
    exp_apb.push_back('{12'h00C, clr});
  endtask

  initial begin
    int n;
    aresetn      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_dir      = 1'b0;
    cmd_base_idx = 3'd0;
    cmd_addr     = 32'd0;
    cmd_cfg      = 32'd0;
    #1;
    chk("rst_ctl", {26'd0, psel, penable, pwrite, busy, done_valid, cmd_ready}, 32'd0);
    chk("rst_paddr", {20'd0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb", {28'd0, pstrb}, 32'hF);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("idle_ready_busy", {30'd0, cmd_ready, busy}, 32'b10);

    // Read channel, slot 2, interrupt 5 cycles after start
    ws_cfg = 0; intr_dly = 5;
    push4(12'h108, 32'h8000_1000, 12'h000, 32'h0000_0045, 32'h1, 32'h1);
    exp_done.push_back(1'b0);
    send(1'b0, 3'd2, 32'h8000_1000, 32'h0000_0045);
    chk("busy_after_accept", {30'd0, busy, cmd_ready}, 32'b10);
    cmd_valid = 1'b1;  // ignored while busy
    cmd_base_idx = 3'd0;
    repeat (3) @(negedge aclk);
    cmd_valid = 1'b0;
    wait_done(100);

    // Write channel, slot 5, three wait states per access
    ws_cfg = 3; intr_dly = 2;
    push4(12'h114, 32'hDEAD_0004, 12'h004, 32'h0000_1234, 32'h2, 32'h2);
    exp_done.push_back(1'b0);
    send(1'b1, 3'd5, 32'hDEAD_0004, 32'h0000_1234);
    wait_done(200);

    // Slot out of range: no bus traffic, immediate error
    ws_cfg = 0;
    exp_done.push_back(1'b1);
    send(1'b0, 3'd6, 32'h1234_5678, 32'h9);
    wait_done(20);
    chk("badidx_latency", {31'd0, (done_cyc - accept_cyc) <= 1}, 32'd1);

    // Slave error on the config write aborts before start
    err_en = 1'b1; err_addr = 12'h000;
    exp_apb.push_back('{12'h100, 32'h0000_2000});
    exp_apb.push_back('{12'h000, 32'h0000_0007});
    exp_done.push_back(1'b1);
    send(1'b0, 3'd0, 32'h0000_2000, 32'h0000_0007);
    wait_done(100);
    err_en = 1'b0;
    push4(12'h10C, 32'h1111_2222, 12'h004, 32'h0000_0033, 32'h2, 32'h2);
    exp_done.push_back(1'b0);
    send(1'b1, 3'd3, 32'h1111_2222, 32'h0000_0033);
    wait_done(100);

`ifdef IDMA_SEQ_TIMEOUT_EN
    // Interrupt never arrives: clear both bits and report error
    intr_dly = 0;
    push4(12'h104, 32'h0BAD_0000, 12'h000, 32'h0000_0011, 32'h1, 32'h3);
    exp_done.push_back(1'b1);
    send(1'b0, 3'd1, 32'h0BAD_0000, 32'h0000_0011);
    wait_done(200);
    intr_dly = 2;
`endif

    // Reset while the step-1 access is stalled
    ws_cfg = 3; intr_dly = 2;
    push4(12'h104, 32'hAAAA_0001, 12'h000, 32'h0000_0005, 32'h1, 32'h1);
    exp_done.push_back(1'b0);
    send(1'b0, 3'd1, 32'hAAAA_0001, 32'h0000_0005);
    n = 0;
    while (!(psel && penable && paddr == 12'h000) && n < 100) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("reached_step1_access", {31'd0, psel && penable && paddr == 12'h000}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_ctl", {28'd0, psel, penable, busy, done_valid}, 32'd0);
    exp_apb.delete();
    exp_done.delete();
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_hold_ctl", {28'd0, psel, penable, busy, done_valid}, 32'd0);
    aresetn = 1'b1;
    ws_cfg = 0;
    push4(12'h110, 32'h4444_0000, 12'h000, 32'h0000_0099, 32'h1, 32'h1);
    exp_done.push_back(1'b0);
    send(1'b0, 3'd4, 32'h4444_0000, 32'h0000_0099);
    wait_done(100);
    repeat (3) @(negedge aclk);
    chk("done_queue_drained", exp_done.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/idma_apb_cmd_sequencer.md
Name: idma_apb_cmd_sequencer

Overview:
- Command-driven APB master that programs the iDMA data/NoC register file on behalf of a requester (e.g. the core's DMA command port).
- Accepts one descriptor at a time, then writes base address, direction config and start registers, waits for the completion interrupt, and clears it.
- Reports done/error to the requester.
- Sits between the command source and the iDMA top-level APB slave port; it is the sole APB master on that port.

Parameters:
- BASE_ADDR0_OFS, 12'h100, APB offset of base_addr_0; base_addr_n is at BASE_ADDR0_OFS + 4*n
- RD_CFG_OFS, 12'h000, APB offset of read-channel config word
- WR_CFG_OFS, 12'h004, APB offset of write-channel config word
- START_OFS, 12'h008, APB offset of start register (bit0 = rd start, bit1 = wr start)
- INTR_CLR_OFS, 12'h00C, APB offset of interrupt clear (W1C; bit0 = rd, bit1 = wr)
- NUM_BASE, 6, number of base-address slots
- TIMEOUT_CYCLES, 65535, interrupt wait limit (optional feature only)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accepted when both high
- cmd_dir  in  1  0 = read channel, 1 = write channel
- cmd_base_idx  in  3  base-address slot 0..NUM_BASE-1
- cmd_addr  in  32  base address value
- cmd_cfg  in  32  channel config word
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done_valid: pslverr, bad index or timeout
- busy  out  1  high from acceptance through done_valid
- paddr  out  12  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  always 1 during transfers
- pstrb  out  4  always 4'hF
- pprot  out  3  always 3'b000
- pwdata  out  32  APB write data
- pready  in  1  APB ready
- prdata  in  32  unused
- pslverr  in  1  APB error
- intr  in  1  level interrupt from iDMA

Behaviour:
- Reset: all outputs 0 except pstrb = 4'hF. FSM = IDLE, step = 0, error flag cleared. Reset mid-transfer abandons the APB access immediately; no completion is reported.
- States: IDLE, SETUP, ACCESS, WAIT_INTR, DONE.
- IDLE: cmd_ready = 1, busy = 0.
  - On cmd_valid & cmd_ready, latch the descriptor and set busy = 1 next cycle.
  - If cmd_base_idx >= NUM_BASE: go to DONE with err = 1; no APB traffic.
  - Otherwise go to SETUP with step = 0.
- Steps (address / data):
  - Step 0: BASE_ADDR0_OFS + 4*idx / cmd_addr.
  - Step 1: (dir ? WR_CFG_OFS : RD_CFG_OFS) / cmd_cfg.
  - Step 2: START_OFS / (1 << dir).
  - Step 3: INTR_CLR_OFS / (1 << dir).
- Address arithmetic is 12-bit; the offset must not overflow for legal idx.
- SETUP: psel = 1, penable = 0; paddr/pwdata driven. Always exactly one cycle, then ACCESS.
- ACCESS: psel = 1, penable = 1; paddr/pwdata held stable.
  - Hold while pready = 0.
  - On pready = 1: OR pslverr into the error flag. Deassert psel/penable next cycle.
  - After step 0 or 1: SETUP with step+1 (back-to-back; no idle cycle between accesses).
  - After step 2: WAIT_INTR.
  - After step 3: DONE.
- APB error handling: an error at step 0 or 1 skips the remaining steps and goes to DONE (no start issued). An error at step 2 goes to DONE. An error at step 3 goes to DONE with err.
- WAIT_INTR: psel = 0. When intr = 1, go to SETUP with step 3. If intr is already high on entry, proceed the next cycle.
- DONE: done_valid = 1 and done_err = error flag for one cycle. busy drops in the same cycle as the transition to IDLE. The next cmd is accepted no earlier than the cycle after DONE.
- Minimum latency with pready tied high: accept → done_valid = 1 + 4×2 APB cycles + WAIT_INTR (≥1) + 1 = 11 cycles.
- cmd_valid while busy is ignored (cmd_ready = 0). Inputs are sampled only at acceptance.

Optional Feature:
- IDMA_SEQ_TIMEOUT_EN defined:
  - 16-bit counter runs in WAIT_INTR, cleared on entry.
  - When it reaches TIMEOUT_CYCLES without intr: set error flag, then go to SETUP step 3 (clear both bits: pwdata = 32'h3), then DONE with done_err = 1.
- Undefined: no counter; WAIT_INTR waits indefinitely for intr.

Test Plan:
- Read cmd (dir = 0, idx = 2, addr = 32'h8000_1000, cfg = 32'h0000_0045), pready = 1, intr raised 5 cycles after start write → APB writes 0x108 = 80001000, 0x000 = 00000045, 0x008 = 1, 0x00C = 1; done_valid with done_err = 0.
- Write cmd (dir = 1, idx = 5), pready low 3 cycles on each access → paddr/pwdata stable throughout; writes to 0x114 and 0x004, start = 2, clear = 2; done_err = 0.
- idx = 6 → no psel assertion; done_valid on the 2nd cycle after acceptance with done_err = 1.
- pslverr = 1 on the step-1 access → no START write; done_err = 1; next cmd accepted normally.
- With IDMA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 20, intr never asserted → clear write pwdata = 3 after 20 cycles; done_err = 1.
- aresetn asserted during ACCESS of step 1 → psel/penable/busy = 0 immediately; no done_valid; a fresh cmd after reset completes normally.
